reservation_station_ooo: RTL

//  Parametrised successor to the single-CDB reservation station: buffers decoded ALU ops until operands are ready.

---
 rtl/rs_pkg.sv | 45 ++++
 rtl/rs_age_matrix.sv | 58 +++++
 rtl/reservation_station_ooo.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/rs_pkg.sv
// Shared widths, op-type encodings, reservation-station entry layout and CDB field extraction.
package rs_pkg;

    localparam int RS_TYPE_WIDTH = 5;
    localparam int RS_ROB_WIDTH  = 4;
    localparam int RS_XLEN       = 32;
    localparam int RS_NUM_CDB    = 2;

    localparam logic [RS_TYPE_WIDTH-1:0] OP_ADD = 5'd0;
    localparam logic [RS_TYPE_WIDTH-1:0] OP_SUB = 5'd1;
    localparam logic [RS_TYPE_WIDTH-1:0] OP_AND = 5'd2;
    localparam logic [RS_TYPE_WIDTH-1:0] OP_OR  = 5'd3;
    localparam logic [RS_TYPE_WIDTH-1:0] OP_XOR = 5'd4;
    localparam logic [RS_TYPE_WIDTH-1:0] OP_SLL = 5'd5;
    localparam logic [RS_TYPE_WIDTH-1:0] OP_SRL = 5'd6;
    localparam logic [RS_TYPE_WIDTH-1:0] OP_SLT = 5'd7;

    typedef struct packed {
        logic                     valid;
        logic [RS_TYPE_WIDTH-1:0] op_type;
        logic [RS_XLEN-1:0]       data_j;
        logic                     pend_j;
        logic [RS_ROB_WIDTH-1:0]  dep_j;
        logic [RS_XLEN-1:0]       data_k;
        logic                     pend_k;
        logic [RS_ROB_WIDTH-1:0]  dep_k;
        logic [RS_ROB_WIDTH-1:0]  rob_id;
        logic [RS_XLEN-1:0]       imm;
    } rs_entry_t;

    function automatic logic [RS_ROB_WIDTH-1:0] cdb_tag_at(
        input logic [RS_NUM_CDB*RS_ROB_WIDTH-1:0] flat,
        input int                                 b
    );
        return flat[b*RS_ROB_WIDTH +: RS_ROB_WIDTH];
    endfunction

    function automatic logic [RS_XLEN-1:0] cdb_data_at(
        input logic [RS_NUM_CDB*RS_XLEN-1:0] flat,
        input int                            b
    );
        return flat[b*RS_XLEN +: RS_XLEN];
    endfunction

endpackage

// File: rtl/rs_age_matrix.sv
// Dispatch-order age matrix: older_q[i][j]=1 means entry i was dispatched before entry j.
// Used by reservation_station_ooo only when RS_OLDEST_FIRST_EN is defined.
module rs_age_matrix #(
    parameter int RS_SIZE = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               en_i,
    input  logic [RS_SIZE-1:0] alloc_i,
    input  logic [RS_SIZE-1:0] free_i,
    input  logic [RS_SIZE-1:0] ready_i,
    output logic [RS_SIZE-1:0] oldest_o
);

    logic [RS_SIZE-1:0] older_q [RS_SIZE];
    logic [RS_SIZE-1:0] older_d [RS_SIZE];

    // Next matrix: freed rows forget their ordering, a new entry is younger than everyone else.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            older_d[i] = free_i[i] ? {RS_SIZE{1'b0}} : older_q[i];
        end
        for (int i = 0; i < RS_SIZE; i++) begin
            if (alloc_i[i]) begin
                older_d[i] = {RS_SIZE{1'b0}};
                for (int j = 0; j < RS_SIZE; j++) begin
                    older_d[j][i] = (j != i) ? 1'b1 : 1'b0;
                end
            end else begin
                older_d[i] = older_d[i];
            end
        end
    end

    // An entry is oldest when no other ready entry is older than it.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            oldest_o[i] = ready_i[i];
            for (int j = 0; j < RS_SIZE; j++) begin
                oldest_o[i] = oldest_o[i] & ~((j != i) && ready_i[j] && older_q[j][i]);
            end
        end
    end

    // Matrix storage, frozen while en_i is low.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                older_q[i] <= {RS_SIZE{1'b0}};
            end
        end else if (en_i) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                older_q[i] <= older_d[i];
            end
        end
    end

endmodule

// File: rtl/reservation_station_ooo.sv
// Multi-CDB reservation station with registered valid/ready issue port.
// Define RS_OLDEST_FIRST_EN for oldest-first select; otherwise lowest-index ready entry issues.
module reservation_station_ooo
    import rs_pkg::*;
#(
    parameter int RS_SIZE    = 8,
    parameter int ROB_WIDTH  = RS_ROB_WIDTH,
    parameter int TYPE_WIDTH = RS_TYPE_WIDTH,
    parameter int XLEN       = RS_XLEN,
    parameter int NUM_CDB    = RS_NUM_CDB
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         rdy_in,
    input  logic                         flush,
    input  logic                         dec_valid,
    output logic                         dec_ready,
    input  logic [TYPE_WIDTH-1:0]        dec_type,
    input  logic [XLEN-1:0]              dec_data_j,
    input  logic [XLEN-1:0]              dec_data_k,
    input  logic                         dec_pend_j,
    input  logic                         dec_pend_k,
    input  logic [ROB_WIDTH-1:0]         dec_dep_j,
    input  logic [ROB_WIDTH-1:0]         dec_dep_k,
    input  logic [ROB_WIDTH-1:0]         dec_rob_id,
    input  logic [XLEN-1:0]              dec_imm,
    input  logic [NUM_CDB-1:0]           cdb_en,
    input  logic [NUM_CDB*ROB_WIDTH-1:0] cdb_rob_id,
    input  logic [NUM_CDB*XLEN-1:0]      cdb_data,
    output logic                         alu_valid,
    input  logic                         alu_ready,
    output logic [TYPE_WIDTH-1:0]        alu_type,
    output logic [ROB_WIDTH-1:0]         alu_rob_id,
    output logic [XLEN-1:0]              alu_data_j,
    output logic [XLEN-1:0]              alu_data_k,
    output logic [XLEN-1:0]              alu_imm,
    output logic [$clog2(RS_SIZE):0]     occupancy
);

    localparam int IDX_W = $clog2(RS_SIZE);
    localparam int OCC_W = IDX_W + 1;
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(RS_SIZE);

    rs_entry_t             entry_q [RS_SIZE];
    rs_entry_t             entry_d [RS_SIZE];
    rs_entry_t             new_entry_s;
    logic [OCC_W-1:0]      occ_q, occ_d;
    logic                  dec_ready_q, dec_ready_d;
    logic                  alu_valid_q, alu_valid_d;
    logic [TYPE_WIDTH-1:0] alu_type_q, alu_type_d;
    logic [ROB_WIDTH-1:0]  alu_rob_q, alu_rob_d;
    logic [XLEN-1:0]       alu_j_q, alu_j_d;
    logic [XLEN-1:0]       alu_k_q, alu_k_d;
    logic [XLEN-1:0]       alu_imm_q, alu_imm_d;

    logic [RS_SIZE-1:0]    valid_s, ready_s, free_oh_s, sel_oh_s;
    logic [IDX_W-1:0]      sel_idx_s;
    logic                  sel_any_s, dispatch_fire_s, issue_fire_s, consume_s;

    // Lowest-indexed matching bus wins, so scan from the top and let lower buses overwrite.
    function automatic logic [XLEN:0] wake_op(
        input logic                         pend,
        input logic [ROB_WIDTH-1:0]         dep,
        input logic [XLEN-1:0]              data,
        input logic [NUM_CDB-1:0]           en,
        input logic [NUM_CDB*ROB_WIDTH-1:0] tags,
        input logic [NUM_CDB*XLEN-1:0]      datas
    );
        logic [XLEN:0] res;
        res = {pend, data};
        for (int b = NUM_CDB - 1; b >= 0; b--) begin
            if (pend && en[b] && (cdb_tag_at(tags, b) == dep)) begin
                res = {1'b0, cdb_data_at(datas, b)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Per-entry status vectors and the lowest free slot.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            valid_s[i] = entry_q[i].valid;
            ready_s[i] = entry_q[i].valid & ~entry_q[i].pend_j & ~entry_q[i].pend_k;
        end
        free_oh_s = ~valid_s & (valid_s + RS_SIZE'(1));
    end

`ifdef RS_OLDEST_FIRST_EN
    logic [RS_SIZE-1:0] age_alloc_s, age_free_s;

    assign age_alloc_s = dispatch_fire_s ? free_oh_s : {RS_SIZE{1'b0}};
    assign age_free_s  = flush ? {RS_SIZE{1'b1}} : (issue_fire_s ? sel_oh_s : {RS_SIZE{1'b0}});

    rs_age_matrix #(
        .RS_SIZE (RS_SIZE)
    ) u_age_matrix (
        .clk_i    (clk_in),
        .rst_ni   (rst_in),
        .en_i     (rdy_in),
        .alloc_i  (age_alloc_s),
        .free_i   (age_free_s),
        .ready_i  (ready_s),
        .oldest_o (sel_oh_s)
    );
`else
    assign sel_oh_s = ready_s & (~ready_s + RS_SIZE'(1));
`endif

    // One-hot select to index; handshake qualifiers.
    always_comb begin
        sel_idx_s = {IDX_W{1'b0}};
        for (int i = 0; i < RS_SIZE; i++) begin
            sel_idx_s = sel_idx_s | (sel_oh_s[i] ? IDX_W'(i) : {IDX_W{1'b0}});
        end
        sel_any_s       = |sel_oh_s;
        consume_s       = alu_valid_q & alu_ready;
        dispatch_fire_s = dec_valid & dec_ready_q & ~flush;
        issue_fire_s    = sel_any_s & (~alu_valid_q | alu_ready) & ~flush;
    end

    // Incoming op with same-cycle CDB capture applied.
    always_comb begin
        logic [XLEN:0] wj, wk;
        wj = wake_op(dec_pend_j, dec_dep_j, dec_data_j, cdb_en, cdb_rob_id, cdb_data);
        wk = wake_op(dec_pend_k, dec_dep_k, dec_data_k, cdb_en, cdb_rob_id, cdb_data);
        new_entry_s.valid   = 1'b1;
        new_entry_s.op_type = dec_type;
        new_entry_s.pend_j  = wj[XLEN];
        new_entry_s.data_j  = wj[XLEN-1:0];
        new_entry_s.dep_j   = dec_dep_j;
        new_entry_s.pend_k  = wk[XLEN];
        new_entry_s.data_k  = wk[XLEN-1:0];
        new_entry_s.dep_k   = dec_dep_k;
        new_entry_s.rob_id  = dec_rob_id;
        new_entry_s.imm     = dec_imm;
    end

    // Entry next state: wakeup everywhere, then dispatch into the free slot, issue frees, flush clears.
    always_comb begin
        logic [XLEN:0] wj, wk;
        for (int i = 0; i < RS_SIZE; i++) begin
            entry_d[i] = entry_q[i];
            wj = wake_op(entry_q[i].pend_j, entry_q[i].dep_j, entry_q[i].data_j,
                         cdb_en, cdb_rob_id, cdb_data);
            wk = wake_op(entry_q[i].pend_k, entry_q[i].dep_k, entry_q[i].data_k,
                         cdb_en, cdb_rob_id, cdb_data);
            entry_d[i].pend_j = wj[XLEN];
            entry_d[i].data_j = wj[XLEN-1:0];
            entry_d[i].pend_k = wk[XLEN];
            entry_d[i].data_k = wk[XLEN-1:0];
            if (dispatch_fire_s && free_oh_s[i]) begin
                entry_d[i] = new_entry_s;
            end else if (issue_fire_s && sel_oh_s[i]) begin
                entry_d[i].valid = 1'b0;
            end else begin
                entry_d[i].valid = entry_q[i].valid;
            end
            entry_d[i].valid = entry_d[i].valid & ~flush;
        end
    end

    // Occupancy and the registered dispatch-ready flag derived from it.
    always_comb begin
        if (flush) begin
            occ_d = {OCC_W{1'b0}};
        end else begin
            occ_d = occ_q + OCC_W'(dispatch_fire_s) - OCC_W'(issue_fire_s);
        end
        dec_ready_d = (occ_d != FULL_OCC);
    end

    // Issue register: load when empty or draining, hold under stall.
    always_comb begin
        alu_valid_d = alu_valid_q;
        alu_type_d  = alu_type_q;
        alu_rob_d   = alu_rob_q;
        alu_j_d     = alu_j_q;
        alu_k_d     = alu_k_q;
        alu_imm_d   = alu_imm_q;
        if (flush) begin
            alu_valid_d = 1'b0;
        end else if (issue_fire_s) begin
            alu_valid_d = 1'b1;
            alu_type_d  = entry_q[sel_idx_s].op_type;
            alu_rob_d   = entry_q[sel_idx_s].rob_id;
            alu_j_d     = entry_q[sel_idx_s].data_j;
            alu_k_d     = entry_q[sel_idx_s].data_k;
            alu_imm_d   = entry_q[sel_idx_s].imm;
        end else if (consume_s) begin
            alu_valid_d = 1'b0;
        end else begin
            alu_valid_d = alu_valid_q;
        end
    end

    // State registers; rdy_in low freezes everything.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                entry_q[i] <= '0;
            end
            occ_q       <= {OCC_W{1'b0}};
            dec_ready_q <= 1'b1;
            alu_valid_q <= 1'b0;
            alu_type_q  <= {TYPE_WIDTH{1'b0}};
            alu_rob_q   <= {ROB_WIDTH{1'b0}};
            alu_j_q     <= {XLEN{1'b0}};
            alu_k_q     <= {XLEN{1'b0}};
            alu_imm_q   <= {XLEN{1'b0}};
        end else if (rdy_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                entry_q[i] <= entry_d[i];
            end
            occ_q       <= occ_d;
            dec_ready_q <= dec_ready_d;
            alu_valid_q <= alu_valid_d;
            alu_type_q  <= alu_type_d;
            alu_rob_q   <= alu_rob_d;
            alu_j_q     <= alu_j_d;
            alu_k_q     <= alu_k_d;
            alu_imm_q   <= alu_imm_d;
        end
    end

    assign dec_ready  = dec_ready_q;
    assign occupancy  = occ_q;
    assign alu_valid  = alu_valid_q;
    assign alu_type   = alu_type_q;
    assign alu_rob_id = alu_rob_q;
    assign alu_data_j = alu_j_q;
    assign alu_data_k = alu_k_q;
    assign alu_imm    = alu_imm_q;

endmodule
